// File: rtl/crtc_monitor.sv
// Sync-side counterpart of the crtc: recovers beam X/Y from hsync/vsync, measures the
// line/frame totals and sync starts, and reports lock once the timing has been stable.
module crtc_monitor #(
   parameter int W           = 10,
   parameter int LOCK_FRAMES = 2
) (
   input  logic         dotclk_i,
   input  logic         reset_i,
   input  logic         hsync_i,
   input  logic         vsync_i,
   output logic [W-1:0] x_o,
   output logic [W-1:0] y_o,
   output logic [W-1:0] htotal_o,
   output logic [W-1:0] hsstart_o,
   output logic [W-1:0] vtotal_o,
   output logic [W-1:0] vsstart_o,
   output logic         frame_o,
   output logic         locked_o
);

   localparam int          CW     = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
   localparam logic [W-1:0] XMAX   = '1;
   localparam logic [W-1:0] X_LOST = {{(W-1){1'b1}}, 1'b0};

   logic          hs_d, vs_d;
   logic          hfall, hrise, vfall, vrise;
   logic          line_err, first_frame;
   logic [CW-1:0] lock_cnt, cnt_inc;
   logic [W-1:0]  ht_prev, hs_prev, vt_prev, vs_prev;
   logic [W-1:0]  ht_new, hs_new, vs_new;
   logic          line_bad, x_lost, frame_match;

   always_comb begin
      hfall    = hs_d & ~hsync_i;
      hrise    = ~hs_d & hsync_i;
      vfall    = vs_d & ~vsync_i;
      vrise    = ~vs_d & vsync_i;
      // Values the measurement registers will hold after this edge; the frame-end
      // qualification compares these against the snapshot of the previous frame.
      ht_new   = hfall ? x_o : htotal_o;
      hs_new   = hrise ? x_o + 1'b1 : hsstart_o;
      vs_new   = vsstart_o;
      if (vrise)
         vs_new = hfall ? y_o + 1'b1 : y_o;
      line_bad = hfall && (x_o != htotal_o);
      x_lost   = !hfall && (x_o >= X_LOST);
      frame_match = (y_o == vt_prev) && (ht_new == ht_prev) &&
                    (hs_new == hs_prev) && (vs_new == vs_prev) && !line_err;
      cnt_inc  = (lock_cnt == CW'(LOCK_FRAMES)) ? lock_cnt : lock_cnt + 1'b1;
   end

   always_ff @(posedge dotclk_i) begin
      if (!reset_i) begin
         hs_d        <= 1'b0;
         vs_d        <= 1'b0;
         x_o         <= '0;
         y_o         <= '0;
         htotal_o    <= '0;
         hsstart_o   <= '0;
         vtotal_o    <= '0;
         vsstart_o   <= '0;
         frame_o     <= 1'b0;
         locked_o    <= 1'b0;
         lock_cnt    <= '0;
         line_err    <= 1'b0;
         first_frame <= 1'b1;
         ht_prev     <= '0;
         hs_prev     <= '0;
         vt_prev     <= '0;
         vs_prev     <= '0;
      end else begin
         hs_d    <= hsync_i;
         vs_d    <= vsync_i;
         frame_o <= vfall;

         if (hfall)
            x_o <= '0;
         else if (x_o != XMAX)
            x_o <= x_o + 1'b1;

         if (hrise)
            hsstart_o <= hs_new;
         if (vrise)
            vsstart_o <= vs_new;

         if (hfall) begin
            htotal_o <= x_o;
            if (!vfall && y_o != XMAX)
               y_o <= y_o + 1'b1;
         end

         if (vfall) begin
            y_o      <= '0;
            vtotal_o <= y_o;
            ht_prev  <= ht_new;
            hs_prev  <= hs_new;
            vt_prev  <= y_o;
            vs_prev  <= vs_new;
            line_err <= 1'b0;
            if (first_frame) begin
               first_frame <= 1'b0;
               lock_cnt    <= '0;
            end else if (frame_match) begin
               lock_cnt <= cnt_inc;
               if (cnt_inc == CW'(LOCK_FRAMES))
                  locked_o <= 1'b1;
            end else begin
               lock_cnt <= '0;
               locked_o <= 1'b0;
            end
         end else if (line_bad) begin
            line_err <= 1'b1;
         end

         // Faults are evaluated last so they override any lock progress made above.
         if (line_bad && locked_o) begin
            locked_o <= 1'b0;
            lock_cnt <= '0;
         end
         if (vfall && !hfall) begin
            locked_o <= 1'b0;
            lock_cnt <= '0;
         end
         if (x_lost) begin
            locked_o    <= 1'b0;
            lock_cnt    <= '0;
            first_frame <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_crtc_monitor.sv
// Bench for crtc_monitor: a behavioural crtc drives the sync inputs; per-frame expectations
// are queued by the stimulus and checked by a monitor at each frame_o pulse.
module tb_crtc_monitor;

   localparam int W     = 10;
   localparam int STALL = 1100;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         hsync, vsync;
   logic [W-1:0] x, y, ht, hss, vt, vss;
   logic         frame, locked;

   int ch, chs, cv, cvs;
   int cx = 0, cy = 0, pcx = 0, pcy = 0;
   int stall_cnt = 0;
   bit stall_arm = 1'b0;
   bit crtc_rst_b;
   bit track_en = 1'b0;
   bit track = 1'b0;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int vt;
      int vs;
      int ht;
      int hs;
      int lk;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   crtc_monitor #(.W(W), .LOCK_FRAMES(2)) dut (
      .dotclk_i  (clk),
      .reset_i   (reset_n),
      .hsync_i   (hsync),
      .vsync_i   (vsync),
      .x_o       (x),
      .y_o       (y),
      .htotal_o  (ht),
      .hsstart_o (hss),
      .vtotal_o  (vt),
      .vsstart_o (vss),
      .frame_o   (frame),
      .locked_o  (locked)
   );

   // Reference crtc: syncs asserted from their start position through the total.
   assign hsync = (cx >= chs);
   assign vsync = (cy >= cvs);

   always @(posedge clk) begin
      pcx <= cx;
      pcy <= cy;
      if (!crtc_rst_b) begin
         cx        <= 0;
         cy        <= 0;
         stall_cnt <= 0;
      end else if (stall_cnt != 0) begin
         stall_cnt <= stall_cnt - 1;
      end else if (stall_arm && cx == 1 && cy == 0) begin
         stall_cnt <= STALL;
      end else if (cx >= ch) begin
         cx <= 0;
         cy <= (cy >= cv) ? 0 : cy + 1;
      end else begin
         cx <= cx + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic push_frames(input int k_first, input int k_last);
      for (int k = k_first; k <= k_last; k++) begin
         exp_t e;
         e.vt = cv;
         e.vs = cvs;
         e.ht = ch;
         e.hs = chs;
         e.lk = (k >= 3) ? 1 : 0;
         q.push_back(e);
      end
   endtask

   task automatic wait_drain(input int limit);
      int n = 0;
      while (q.size() != 0 && n < limit) begin
         step(1);
         n++;
      end
      chk("frames_pending", q.size(), 0);
      q.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_x"}, int'(x), 0);
      chk({tag, "_y"}, int'(y), 0);
      chk({tag, "_htotal"}, int'(ht), 0);
      chk({tag, "_hsstart"}, int'(hss), 0);
      chk({tag, "_vtotal"}, int'(vt), 0);
      chk({tag, "_vsstart"}, int'(vss), 0);
      chk({tag, "_frame"}, int'(frame), 0);
      chk({tag, "_locked"}, int'(locked), 0);
   endtask

   // Monitor: beam trailing check every cycle once synced, measurement check per frame.
   initial begin
      forever begin
         @(negedge clk);
         if (!track_en)
            track = 1'b0;
         if (track) begin
            chk("x_trail", int'(x), pcx);
            chk("y_trail", int'(y), pcy);
         end
         if (frame) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: frame_o pulse with no expectation at %0t", $time);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("vtotal", int'(vt), e.vt);
               chk("vsstart", int'(vss), e.vs);
               chk("htotal", int'(ht), e.ht);
               chk("hsstart", int'(hss), e.hs);
               chk("locked", int'(locked), e.lk);
               chk("y_at_frame", int'(y), 0);
            end
            if (track_en)
               track = 1'b1;
         end
      end
   end

   initial begin
      int n;
      reset_n    = 1'b0;
      crtc_rst_b = 1'b0;
      ch = 5; chs = 3; cv = 3; cvs = 2;
      step(3);
      chk_all_zero("reset");

      // Power-up acquisition: lock after the third frame.
      push_frames(1, 5);
      reset_n    = 1'b1;
      crtc_rst_b = 1'b1;
      track_en   = 1'b1;
      wait_drain(400);

      // Line length change while locked.
      step(2);
      ch = 6;
      push_frames(1, 4);
      n = 0;
      while (locked === 1'b1 && n < 20) begin
         step(1);
         n++;
      end
      chk("unlock_on_hfall", int'(locked), 0);
      chk("htotal_after_change", int'(ht), 6);
      wait_drain(400);

      // hsync lost: crtc stalls in line 0 with syncs low.
      step(3);
      push_frames(5, 5);
      track_en  = 1'b0;
      stall_arm = 1'b1;
      n = 0;
      while (stall_cnt == 0 && n < 100) begin
         step(1);
         n++;
      end
      chk("stall_started", (stall_cnt != 0) ? 1 : 0, 1);
      stall_arm = 1'b0;
      chk("frames_before_stall", q.size(), 0);
      step(1060);
      chk("x_saturated", int'(x), 1023);
      chk("unlock_on_lost", int'(locked), 0);
      chk("y_during_stall", int'(y), 0);
      push_frames(1, 4);
      track_en = 1'b1;
      wait_drain(400);

      // One-cycle monitor reset mid-line while locked.
      chk("locked_before_reset", int'(locked), 1);
      n = 0;
      while (!(cx == 1 && cy == 0) && n < 100) begin
         step(1);
         n++;
      end
      reset_n  = 1'b0;
      track_en = 1'b0;
      step(1);
      chk_all_zero("midreset");
      reset_n  = 1'b1;
      track_en = 1'b1;
      push_frames(1, 4);
      wait_drain(400);

      // Randomized timings, full restart of both crtc and monitor each time.
      for (int r = 0; r < 6; r++) begin
         track_en   = 1'b0;
         reset_n    = 1'b0;
         crtc_rst_b = 1'b0;
         ch  = $urandom_range(12, 4);
         chs = $urandom_range(ch, 1);
         cv  = $urandom_range(6, 2);
         cvs = $urandom_range(cv, 1);
         step(2);
         chk("rand_reset_locked", int'(locked), 0);
         push_frames(1, 4);
         reset_n    = 1'b1;
         crtc_rst_b = 1'b1;
         track_en   = 1'b1;
         wait_drain(6 * (ch + 1) * (cv + 1) + 50);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
